// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the FSM encoding, the parity mode enum and the bit-period calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  // Integer division truncates, so non-integer ratios run slightly fast.
  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter. There is no bypass path:
// a pushed entry becomes visible to the reader one edge later.
module uart_tx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             push_en, pop_en;

  assign push_en = push && !full_q;
  assign pop_en  = pop && (level_q != '0);

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_W'(DEPTH));
  end

  // NOTE: state flops use non-blocking assignments and a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // NOTE: storage is not reset; the level counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered valid/ready input, one frame per byte
// (start, LSB-first data, optional parity, 1-2 stop bits), frames sent back-to-back.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  output logic                        ready,
  input  logic [DATA_BITS-1:0]        data,
  output logic                        dout,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int      BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int      CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam parity_e PAR_MODE   = parity_e'(PARITY[1:0]);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end
  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   dout_q, dout_d;
  logic                   load;
  logic                   bit_wrap, last_data, last_stop;
  logic                   fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]   fifo_rdata;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (valid),
    .wdata (data),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_wrap  = (baud_q == CNT_W'(BIT_CYCLES - 1));
  assign last_data = (bit_q == 3'(DATA_BITS - 1));
  assign last_stop = (bit_q == 3'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!fifo_empty) state_d = ST_START;
      ST_START:  if (bit_wrap) state_d = ST_DATA;
      ST_DATA:   if (bit_wrap && last_data) state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (bit_wrap) state_d = ST_STOP;
      ST_STOP:   if (bit_wrap && last_stop) state_d = fifo_empty ? ST_IDLE : ST_START;
      default:   state_d = ST_IDLE;
    endcase
  end

  // START is only ever entered by popping a new byte, from IDLE or straight out of STOP.
  always_comb begin
    load    = (state_d == ST_START) && (state_q != ST_START);
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    if (load || bit_wrap)        baud_d = '0;
    else if (state_q != ST_IDLE) baud_d = baud_q + CNT_W'(1);
    if (load) begin
      bit_d   = '0;
      shift_d = fifo_rdata;
      par_d   = (PAR_MODE == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
    end else if (bit_wrap) begin
      bit_d = (state_d != state_q) ? 3'd0 : bit_q + 3'd1;
      if (state_q == ST_DATA) shift_d = shift_q >> 1;
    end
    // The line level is registered from the next state so the pin never glitches.
    unique case (state_d)
      ST_START:  dout_d = 1'b0;
      ST_DATA:   dout_d = shift_d[0];
      ST_PARITY: dout_d = par_q;
      default:   dout_d = 1'b1;
    endcase
  end

  assign dout  = dout_q;
  assign busy  = (state_q != ST_IDLE) || !fifo_empty;
  assign ready = !fifo_full;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four configurations share one clock; a monitor
// per lane decodes frames from the serial line and compares them with queued expectations.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Lane 0: 8N1, lane 1: 7E2, lane 2: 7O2, lane 3: 8N1 at 9600 baud from a 10 MHz clock.
  logic       rst_v   [4];
  logic       valid_v [4];
  logic [7:0] data_v  [4];
  logic       ready_v [4];
  logic       dout_v  [4];
  logic       busy_v  [4];
  logic [2:0] lvl_v   [4];

  int checks   = 0;
  int failures = 0;

  string exp_q   [4][$];
  int    start_q [4][$];

  function automatic int bc_of(input int ln);
    return (ln == 3) ? 1041 : 100;
  endfunction

  uart_tx_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst_v[0]), .valid(valid_v[0]), .ready(ready_v[0]), .data(data_v[0]),
    .dout(dout_v[0]), .busy(busy_v[0]), .fifo_level(lvl_v[0]));

  uart_tx_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
    .clk(clk), .rst(rst_v[1]), .valid(valid_v[1]), .ready(ready_v[1]), .data(data_v[1][6:0]),
    .dout(dout_v[1]), .busy(busy_v[1]), .fifo_level(lvl_v[1]));

  uart_tx_param #(.CLK_FREQ(100_000_000), .BAUD_RATE(1_000_000), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
    .clk(clk), .rst(rst_v[2]), .valid(valid_v[2]), .ready(ready_v[2]), .data(data_v[2][6:0]),
    .dout(dout_v[2]), .busy(busy_v[2]), .fifo_level(lvl_v[2]));

  uart_tx_param #(.CLK_FREQ(10_000_000), .BAUD_RATE(9600), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_slow (
    .clk(clk), .rst(rst_v[3]), .valid(valid_v[3]), .ready(ready_v[3]), .data(data_v[3]),
    .dout(dout_v[3]), .busy(busy_v[3]), .fifo_level(lvl_v[3]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %s, expected %s", name, got, exp);
    end
  endtask

  // Line monitor: samples each bit at its first, middle and last clock.
  for (genvar g = 0; g < 4; g++) begin : g_mon
    logic  active = 1'b0;
    logic  have_exp;
    logic  e_s, m_s, t_ok;
    int    cnt, len, pos, k;
    string got, expb;

    always @(negedge clk) begin
      if (rst_v[g] !== 1'b1) begin
        active = 1'b0;
      end else begin
        if (!active && dout_v[g] === 1'b0) begin
          active = 1'b1;
          cnt    = 0;
          got    = "";
          t_ok   = 1'b1;
          start_q[g].push_back(cyc);
          have_exp = (exp_q[g].size() > 0);
          expb     = have_exp ? exp_q[g].pop_front() : "";
          len      = have_exp ? expb.len() : 10;
        end
        if (active) begin
          pos = cnt % bc_of(g);
          k   = cnt / bc_of(g);
          if (pos == 0) e_s = dout_v[g];
          if (pos == bc_of(g) / 2) begin
            m_s = dout_v[g];
            if (m_s === 1'b1) got = {got, "1"};
            else              got = {got, "0"};
            if (m_s !== e_s) t_ok = 1'b0;
          end
          if (pos == bc_of(g) - 1) begin
            if (dout_v[g] !== m_s) t_ok = 1'b0;
            if (k == len - 1) begin
              if (have_exp) check_str($sformatf("lane%0d frame", g), got, expb);
              else          check_str($sformatf("lane%0d unexpected frame", g), got, "none");
              check($sformatf("lane%0d bit timing", g), 32'(t_ok), 32'd1);
              active = 1'b0;
            end
          end
          cnt++;
        end
      end
    end
  end

  task automatic wait_ready(input int ln, output logic ok);
    int t = 0;
    while (ready_v[ln] !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    ok = (ready_v[ln] === 1'b1);
    if (!ok) check($sformatf("lane%0d ready timeout", ln), 32'd0, 32'd1);
  endtask

  // Offers one byte; acc returns the cycle number of the accepting edge.
  task automatic send(input int ln, input logic [7:0] d, input string f, output int acc);
    logic ok;
    valid_v[ln] = 1'b1;
    data_v[ln]  = d;
    wait_ready(ln, ok);
    acc = cyc + 1;
    if (ok && f.len() > 0) exp_q[ln].push_back(f);
    @(negedge clk);
    valid_v[ln] = 1'b0;
  endtask

  task automatic wait_idle(input int ln, input int limit, output int fall);
    int t = 0;
    while (busy_v[ln] !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    fall = cyc;
    check($sformatf("lane%0d idle", ln), 32'(busy_v[ln]), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int    acc, acc2, fall, fall2, s, n0, t;
    logic  ok;
    string burst_f [5];
    burst_f = '{"0100000001", "0010000001", "0110000001", "0001000001", "0101000001"};

    for (int i = 0; i < 4; i++) begin
      rst_v[i]   = 1'b0;
      valid_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lane%0d reset dout", i),  32'(dout_v[i]),  32'd1);
      check($sformatf("lane%0d reset busy", i),  32'(busy_v[i]),  32'd0);
      check($sformatf("lane%0d reset ready", i), 32'(ready_v[i]), 32'd1);
      check($sformatf("lane%0d reset level", i), 32'(lvl_v[i]),   32'd0);
    end
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b1;
    @(negedge clk);

    // 8N1 A5: start one clock after accept, busy for the whole 10-bit frame.
    send(0, 8'hA5, "0101001011", acc);
    wait_idle(0, 3000, fall);
    s = start_q[0][$];
    check("t1 start latency", 32'(s - acc), 32'd1);
    check("t1 frame length", 32'(fall - s), 32'd1000);

    // 7-bit 0x55 with even and odd parity, two stop bits.
    send(1, 8'h55, "01010101011", acc);
    send(2, 8'h55, "01010101111", acc2);
    fork
      wait_idle(1, 3000, fall);
      wait_idle(2, 3000, fall2);
    join
    check("t2 even frame length", 32'(fall - start_q[1][$]), 32'd1100);
    check("t2 odd frame length", 32'(fall2 - start_q[2][$]), 32'd1100);

    // Burst of five with valid held high, then extra offers while full.
    n0 = start_q[0].size();
    valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_v[0] = 8'(i + 1);
      wait_ready(0, ok);
      if (ok) exp_q[0].push_back(burst_f[i]);
      @(negedge clk);
    end
    check("t3 ready while full", 32'(ready_v[0]), 32'd0);
    check("t3 level full", 32'(lvl_v[0]), 32'd4);
    data_v[0] = 8'hEE;
    repeat (3) @(negedge clk);
    check("t3 level held while full", 32'(lvl_v[0]), 32'd4);
    check("t3 ready held low", 32'(ready_v[0]), 32'd0);
    valid_v[0] = 1'b0;
    wait_idle(0, 8000, fall);
    check("t3 frame count", 32'(start_q[0].size() - n0), 32'd5);
    for (int i = 1; i < 5; i++)
      check($sformatf("t3 start gap %0d", i),
            32'(start_q[0][n0 + i] - start_q[0][n0 + i - 1]), 32'd1000);

    // Reset during the fourth data bit of 3C, then a clean FF frame.
    n0 = start_q[0].size();
    send(0, 8'h3C, "", acc);
    t = 0;
    while (start_q[0].size() <= n0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4 abort frame started", 32'(start_q[0].size() - n0), 32'd1);
    s = start_q[0][$];
    while (cyc < s + 450 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    rst_v[0] = 1'b0;
    @(negedge clk);
    check("t4 abort dout", 32'(dout_v[0]), 32'd1);
    check("t4 abort busy", 32'(busy_v[0]), 32'd0);
    check("t4 abort level", 32'(lvl_v[0]), 32'd0);
    check("t4 abort ready", 32'(ready_v[0]), 32'd1);
    @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    send(0, 8'hFF, "0111111111", acc);
    wait_idle(0, 3000, fall);
    check("t4 clean frame latency", 32'(start_q[0][$] - acc), 32'd1);
    check("t4 clean frame length", 32'(fall - start_q[0][$]), 32'd1000);

    // Push on the edge the FSM pops, with three bytes already queued.
    send(0, 8'h11, "0100010001", acc);
    send(0, 8'h22, "0010001001", acc2);
    send(0, 8'h33, "0110011001", acc2);
    send(0, 8'h44, "0001000101", acc2);
    t = 0;
    while (cyc < acc + 1000 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("t6 level before", 32'(lvl_v[0]), 32'd3);
    check("t6 ready before", 32'(ready_v[0]), 32'd1);
    valid_v[0] = 1'b1;
    data_v[0]  = 8'h55;
    exp_q[0].push_back("0101010101");
    @(negedge clk);
    valid_v[0] = 1'b0;
    check("t6 level unchanged", 32'(lvl_v[0]), 32'd3);
    check("t6 ready stays", 32'(ready_v[0]), 32'd1);
    @(negedge clk);
    check("t6 pop edge", 32'(start_q[0][$]), 32'(acc + 1001));
    wait_idle(0, 6000, fall);

    // Non-integer clock/baud ratio: every bit exactly 1041 clocks.
    send(3, 8'h00, "0000000001", acc);
    wait_idle(3, 12000, fall);
    check("t5 start latency", 32'(start_q[3][$] - acc), 32'd1);
    check("t5 frame length", 32'(fall - start_q[3][$]), 32'd10410);

    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("lane%0d leftover expected frames", i), 32'(exp_q[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
